// File: rtl/map_wr_arbiter.sv
// Tile-map write port arbiter: round-robin grants from bullet-hit requesters,
// with a full-map fill sequence for level load/clear that preempts arbitration.
module map_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 3,
  parameter int ADDR_WIDTH = 15,
  parameter int MAP_DEPTH  = 192
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0]  req_data,
  output logic [N_REQ-1:0]             gnt,
  input  logic                         clr_start,
  input  logic [DATA_WIDTH-1:0]        clr_data,
  output logic                         busy,
  output logic                         clr_done,
  output logic                         addr_err,
  output logic                         we,
  output logic [ADDR_WIDTH-1:0]        wr_addr,
  output logic [DATA_WIDTH-1:0]        wr_data
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (MAP_DEPTH > 1) ? $clog2(MAP_DEPTH) : 1;
  localparam logic [CNT_W-1:0]      FILL_LAST = CNT_W'(MAP_DEPTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(MAP_DEPTH);
  localparam logic [IDX_W-1:0]      LAST_RST  = IDX_W'(N_REQ - 1);

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_FILL = 1'b1
  } state_t;

  state_t                  r_state;
  logic [N_REQ-1:0]        r_gnt;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_wr_addr;
  logic [DATA_WIDTH-1:0]   r_wr_data;
  logic                    r_busy;
  logic                    r_clr_done;
  logic                    r_addr_err;
  logic [IDX_W-1:0]        r_last;
  logic [CNT_W-1:0]        r_fill_cnt;
  logic [DATA_WIDTH-1:0]   r_fill_code;

  state_t                  w_state_next;
  logic [N_REQ-1:0]        w_gnt_next;
  logic                    w_we_next;
  logic [ADDR_WIDTH-1:0]   w_wr_addr_next;
  logic [DATA_WIDTH-1:0]   w_wr_data_next;
  logic                    w_busy_next;
  logic                    w_clr_done_next;
  logic                    w_addr_err_next;
  logic [IDX_W-1:0]        w_last_next;
  logic [CNT_W-1:0]        w_fill_cnt_next;
  logic [DATA_WIDTH-1:0]   w_fill_code_next;

  logic [ADDR_WIDTH-1:0]   w_slot_addr [N_REQ];
  logic [DATA_WIDTH-1:0]   w_slot_data [N_REQ];
  logic [N_REQ-1:0]        w_elig;
  logic                    w_found;
  logic [IDX_W-1:0]        w_sel;
  logic [IDX_W-1:0]        w_idx;
  logic [ADDR_WIDTH-1:0]   w_sel_addr;
  logic [DATA_WIDTH-1:0]   w_sel_data;
  logic                    w_sel_oob;
  logic                    w_do_arb;
  logic [CNT_W-1:0]        w_cnt_inc;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_slot
      assign w_slot_addr[gi] = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_slot_data[gi] = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // A requester granted this cycle is still showing req; mask it out.
  assign w_elig = req & ~r_gnt;

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = IDX_W'((int'(r_last) + k) % N_REQ);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  assign w_sel_addr = w_slot_addr[w_sel];
  assign w_sel_data = w_slot_data[w_sel];
  assign w_sel_oob  = ({1'b0, w_sel_addr} >= DEPTH_EXT);
  assign w_cnt_inc  = r_fill_cnt + CNT_W'(1);

  always_comb begin
    w_state_next     = r_state;
    w_gnt_next       = '0;
    w_we_next        = 1'b0;
    w_wr_addr_next   = r_wr_addr;
    w_wr_data_next   = r_wr_data;
    w_busy_next      = r_busy;
    w_clr_done_next  = 1'b0;
    w_addr_err_next  = 1'b0;
    w_last_next      = r_last;
    w_fill_cnt_next  = r_fill_cnt;
    w_fill_code_next = r_fill_code;
    w_do_arb         = 1'b0;

    case (r_state)
      ST_ARB: begin
        if (clr_start) begin
          w_state_next     = ST_FILL;
          w_fill_code_next = clr_data;
          w_fill_cnt_next  = '0;
          w_we_next        = 1'b1;
          w_wr_addr_next   = '0;
          w_wr_data_next   = clr_data;
          w_busy_next      = 1'b1;
        end else begin
          w_do_arb = 1'b1;
        end
      end
      ST_FILL: begin
        if (r_fill_cnt == FILL_LAST) begin
          // Fill finished; arbitration resumes on this same edge.
          w_state_next    = ST_ARB;
          w_busy_next     = 1'b0;
          w_clr_done_next = 1'b1;
          w_do_arb        = 1'b1;
        end else begin
          w_fill_cnt_next             = w_cnt_inc;
          w_we_next                   = 1'b1;
          w_wr_addr_next              = '0;
          w_wr_addr_next[CNT_W-1:0]   = w_cnt_inc;
          w_wr_data_next              = r_fill_code;
        end
      end
      default: begin
        w_state_next = ST_ARB;
      end
    endcase

    if (w_do_arb && w_found) begin
      w_gnt_next[w_sel] = 1'b1;
      w_last_next       = w_sel;
      if (w_sel_oob) begin
        // Out-of-range target: consume the request without touching the RAM.
        w_addr_err_next = 1'b1;
      end else begin
        w_we_next      = 1'b1;
        w_wr_addr_next = w_sel_addr;
        w_wr_data_next = w_sel_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_ARB;
      r_gnt       <= '0;
      r_we        <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_busy      <= 1'b0;
      r_clr_done  <= 1'b0;
      r_addr_err  <= 1'b0;
      r_last      <= LAST_RST;
      r_fill_cnt  <= '0;
      r_fill_code <= '0;
    end else begin
      r_state     <= w_state_next;
      r_gnt       <= w_gnt_next;
      r_we        <= w_we_next;
      r_wr_addr   <= w_wr_addr_next;
      r_wr_data   <= w_wr_data_next;
      r_busy      <= w_busy_next;
      r_clr_done  <= w_clr_done_next;
      r_addr_err  <= w_addr_err_next;
      r_last      <= w_last_next;
      r_fill_cnt  <= w_fill_cnt_next;
      r_fill_code <= w_fill_code_next;
    end
  end

  assign gnt      = r_gnt;
  assign we       = r_we;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign busy     = r_busy;
  assign clr_done = r_clr_done;
  assign addr_err = r_addr_err;

endmodule

// File: doc/map_wr_arbiter.md
MAP_WR_ARBITER -- requirements
Module: map_wr_arbiter

Interface
REQ-001 Parameters SHALL be: N_REQ, default 4, number of write requesters (player/enemy bullet hit logic).
REQ-002 Parameters SHALL be: DATA_WIDTH, default 3, tile code width.
REQ-003 Parameters SHALL be: ADDR_WIDTH, default 15, map address width.
REQ-004 Parameters SHALL be: MAP_DEPTH, default 192, tile count (16x12).
REQ-005 Port clk SHALL be input, width 1: single clock, rising edge.
REQ-006 Port rst SHALL be input, width 1: reset, synchronous, active-high.
REQ-007 Port req SHALL be input, width N_REQ: per-requester write request.
REQ-008 Port req_addr SHALL be input, width N_REQ*ADDR_WIDTH: packed tile addresses; requester i uses slice i.
REQ-009 Port req_data SHALL be input, width N_REQ*DATA_WIDTH: packed tile codes; requester i uses slice i.
REQ-010 Port gnt SHALL be output, width N_REQ: one-cycle grant pulse.
REQ-011 Port clr_start SHALL be input, width 1: start a full-map fill (level load/clear).
REQ-012 Port clr_data SHALL be input, width DATA_WIDTH: fill tile code.
REQ-013 Port busy SHALL be output, width 1: fill in progress.
REQ-014 Port clr_done SHALL be output, width 1: one-cycle pulse when the fill completes.
REQ-015 Port addr_err SHALL be output, width 1: one-cycle pulse when a granted address is >= MAP_DEPTH.
REQ-016 Port we SHALL be output, width 1: map RAM write enable.
REQ-017 Port wr_addr SHALL be output, width ADDR_WIDTH: map RAM write address.
REQ-018 Port wr_data SHALL be output, width DATA_WIDTH: map RAM write data.

Function
REQ-019 All outputs SHALL be registered; the map RAM samples we/wr_addr/wr_data on the following rising edge of clk.
REQ-020 FSM SHALL have two states: ARB (reset state) and FILL.
REQ-021 In ARB, with clr_start=0 and any eligible req, the block SHALL grant exactly one requester per edge: gnt[i]=1, we=1, wr_addr=slice i, wr_data=slice i, all appearing on that edge (latency 1 cycle from req to gnt/we).
REQ-022 Arbitration SHALL be round-robin: search starts at (last_granted+1) mod N_REQ; last_granted resets to N_REQ-1, so requester 0 has first priority.
REQ-023 A requester whose gnt is high in the current cycle SHALL be ineligible in that cycle; max one grant per requester every two cycles; aggregate one write per cycle.
REQ-024 Requesters SHALL hold req, addr, and data stable until gnt; req without gnt SHALL never be dropped by the block.
REQ-025 If the granted address is >= MAP_DEPTH, the block SHALL pulse gnt[i] and addr_err, hold we=0, and advance the round-robin pointer.
REQ-026 With no eligible req in ARB, the block SHALL drive gnt=0, we=0, and addr_err=0; wr_addr and wr_data SHALL hold their previous values.
REQ-027 In ARB, clr_start=1 SHALL take priority over all req in the same cycle (no gnt that edge), latch clr_data, enter FILL, and register we=1, wr_addr=0, wr_data=latched code, busy=1.
REQ-028 In FILL, the block SHALL write addresses 0..MAP_DEPTH-1, one per cycle, 192 consecutive we=1 cycles, using the latched code; clr_data changes during FILL SHALL be ignored.
REQ-029 On the edge after the MAP_DEPTH-1 write, the block SHALL drive we=0, busy=0, and clr_done=1 for one cycle, and return to ARB; grants SHALL be able to resume on that same edge.
REQ-030 In FILL, clr_start SHALL be ignored, gnt SHALL be 0, and pending req SHALL be held; the round-robin pointer SHALL be unchanged.
REQ-031 The fill address counter SHALL be ceil(log2(MAP_DEPTH)) bits, zero-extended to ADDR_WIDTH; it SHALL never wrap past MAP_DEPTH-1.

Reset
REQ-032 rst=1 on an edge SHALL force state ARB, gnt=0, we=0, wr_addr=0, wr_data=0, busy=0, clr_done=0, addr_err=0, and last_granted=N_REQ-1.
REQ-033 rst during FILL SHALL abort the fill immediately; remaining addresses SHALL stay unwritten and clr_done SHALL not pulse.
REQ-034 rst SHALL have priority over clr_start and req in the same cycle.

Verification
REQ-035 Bench SHALL cover: req=4'b1111 held continuously -> grants in order 0,1,2,3,0...; no requester granted on consecutive cycles; we=1 every cycle.
REQ-036 Bench SHALL cover: req0 with addr=200 -> gnt[0]=1, addr_err=1, we=0; the next grant goes to requester 1 if it is requesting.
REQ-037 Bench SHALL cover: clr_start=1, clr_data=3'b001 with req=4'b0010 in the same cycle -> no gnt; 192 writes of addrs 0..191 with data 001; clr_done after 192 cycles; gnt[1] on the clr_done edge.
REQ-038 Bench SHALL cover: clr_start pulsed again at fill address 50 -> ignored; fill completes at 191 with a single clr_done.
REQ-039 Bench SHALL cover: rst at fill address 100 -> next edge all outputs 0, busy=0, no clr_done; the RAM holds fill data at 0..99 only.
REQ-040 Bench SHALL cover: single req3 after reset -> gnt[3] on the first edge, wr_addr and wr_data equal to slice 3; the following req0 is granted next.
